temp_window_avg: RTL and testbench

TEMP_WINDOW_AVG -- requirements
Module: temp_window_avg

---
 rtl/temp_window_avg.sv | 145 ++++++++++++++
 tb/tb_temp_window_avg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/temp_window_avg.sv
// temp_window_avg: per-channel sliding-block average of sign-magnitude
// temperature samples taken every TICKS_PER_SAMPLE cycles over 2^LOG2_WINDOW
// samples, with valid/ack handshake, overrun flag and threshold alarm.
module temp_window_avg #(
    parameter int unsigned CHANNELS         = 4,
    parameter int unsigned DATA_W           = 9,
    parameter int unsigned TICKS_PER_SAMPLE = 50000000,
    parameter int unsigned LOG2_WINDOW      = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         oneshot,
    input  logic [CHANNELS*DATA_W-1:0]   temp,
    input  logic [DATA_W-1:0]            thresh,
    input  logic                         avg_ack,
    output logic [CHANNELS*DATA_W-1:0]   avg,
    output logic                         avg_valid,
    output logic                         overrun,
    output logic [CHANNELS-1:0]          alarm,
    output logic [LOG2_WINDOW-1:0]       sample_idx,
    output logic                         busy
);

    localparam int unsigned ACC_W  = DATA_W + LOG2_WINDOW;
    localparam int unsigned TICK_W = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SAMPLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                      r_state;
    logic [TICK_W-1:0]           r_tick;
    logic [LOG2_WINDOW-1:0]      r_idx;
    logic signed [ACC_W-1:0]     r_acc [CHANNELS];
    logic [CHANNELS*DATA_W-1:0]  r_avg;
    logic                        r_avg_valid;
    logic                        r_overrun;
    logic [CHANNELS-1:0]         r_alarm;
    logic                        r_busy;

    logic [ACC_W-1:0]            w_mag     [CHANNELS];
    logic signed [ACC_W-1:0]     w_samp    [CHANNELS];
    logic signed [ACC_W-1:0]     w_sum     [CHANNELS];
    logic [CHANNELS*DATA_W-1:0]  w_new_avg;
    logic [CHANNELS-1:0]         w_new_alarm;
    logic                        w_strobe;
    logic                        w_last;

    // Sample conversion, running sums and the would-be average/alarm at completion
    always_comb begin
        w_strobe    = (r_tick == TICK_LAST);
        w_last      = &r_idx;
        w_new_avg   = '0;
        w_new_alarm = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_mag[c]  = {{(LOG2_WINDOW + 1){1'b0}}, temp[c*DATA_W +: (DATA_W - 1)]};
            // negative zero maps to 0 because 0 - 0 = 0
            w_samp[c] = temp[c*DATA_W + DATA_W - 1] ? (ACC_W'(0) - w_mag[c]) : w_mag[c];
            w_sum[c]  = r_acc[c] + w_samp[c];
            // dropping the low LOG2_WINDOW bits is a flooring arithmetic shift
            w_new_avg[c*DATA_W +: DATA_W] = w_sum[c][ACC_W-1:LOG2_WINDOW];
            w_new_alarm[c] = $signed(w_sum[c][ACC_W-1:LOG2_WINDOW]) >= $signed(thresh);
        end
    end

    // Control FSM, sample accumulation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tick      <= '0;
            r_idx       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_alarm     <= '0;
            r_busy      <= 1'b0;
            for (int c = 0; c < int'(CHANNELS); c++) r_acc[c] <= '0;
        end else begin
            // consumer ack; a coincident completion below takes precedence
            if (avg_ack) begin
                r_avg_valid <= 1'b0;
                r_overrun   <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_ACCUM;
                        r_busy  <= 1'b1;
                        r_tick  <= '0;
                        r_idx   <= '0;
                        for (int c = 0; c < int'(CHANNELS); c++) r_acc[c] <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (!en) begin
                        // abandon the partial window, keep the last result
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_tick  <= '0;
                        r_idx   <= '0;
                        for (int c = 0; c < int'(CHANNELS); c++) r_acc[c] <= '0;
                    end else begin
                        r_tick <= w_strobe ? '0 : r_tick + TICK_W'(1);
                        if (w_strobe) begin
                            if (w_last) begin
                                r_avg       <= w_new_avg;
                                r_alarm     <= w_new_alarm;
                                r_avg_valid <= 1'b1;
                                r_overrun   <= avg_ack ? r_overrun : (r_overrun | r_avg_valid);
                                r_idx       <= '0;
                                for (int c = 0; c < int'(CHANNELS); c++) r_acc[c] <= '0;
                                if (oneshot) begin
                                    r_state <= ST_HOLD;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_idx <= r_idx + LOG2_WINDOW'(1);
                                for (int c = 0; c < int'(CHANNELS); c++) r_acc[c] <= w_sum[c];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!en) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign avg        = r_avg;
    assign avg_valid  = r_avg_valid;
    assign overrun    = r_overrun;
    assign alarm      = r_alarm;
    assign sample_idx = r_idx;
    assign busy       = r_busy;

endmodule

// File: tb/tb_temp_window_avg.sv
// Self-checking bench for temp_window_avg with a scoreboard of expected window results.
module tb_temp_window_avg;

    localparam int unsigned CH = 2;
    localparam int unsigned DW = 9;
    localparam int unsigned TPS = 4;
    localparam int unsigned LW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              oneshot;
    logic [CH*DW-1:0]  temp;
    logic [DW-1:0]     thresh;
    logic              avg_ack;
    logic [CH*DW-1:0]  avg;
    logic              avg_valid;
    logic              overrun;
    logic [CH-1:0]     alarm;
    logic [LW-1:0]     sample_idx;
    logic              busy;

    typedef struct {
        logic [8:0] a0;
        logic [8:0] a1;
        logic [1:0] al;
    } exp_t;

    exp_t       sbq[$];
    exp_t       m_e;
    logic [8:0] w0 [4];
    logic [8:0] w1 [4];
    int         n_checks = 0;
    int         n_pass   = 0;

    temp_window_avg #(
        .CHANNELS(CH), .DATA_W(DW), .TICKS_PER_SAMPLE(TPS), .LOG2_WINDOW(LW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .oneshot(oneshot), .temp(temp),
        .thresh(thresh), .avg_ack(avg_ack), .avg(avg), .avg_valid(avg_valid),
        .overrun(overrun), .alarm(alarm), .sample_idx(sample_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Count one comparison and report it on mismatch
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int sm2int(input logic [8:0] s);
        return s[8] ? -int'(s[7:0]) : int'(s[7:0]);
    endfunction

    // Drive ns samples per channel from w0/w1; push the expected result for a full window
    task automatic drive_window(input int ns, input int ack_at);
        int   sum0;
        int   sum1;
        exp_t e;
        sum0 = 0;
        sum1 = 0;
        if (ns == 4) begin
            for (int k = 0; k < 4; k++) begin
                sum0 += sm2int(w0[k]);
                sum1 += sm2int(w1[k]);
            end
            e.a0    = 9'(sum0 >>> 2);
            e.a1    = 9'(sum1 >>> 2);
            e.al[0] = $signed(e.a0) >= $signed(thresh);
            e.al[1] = $signed(e.a1) >= $signed(thresh);
            sbq.push_back(e);
        end
        for (int i = 0; i < 4 * ns; i++) begin
            if (i % 4 == 0) temp = {w1[i/4], w0[i/4]};
            avg_ack = (i == ack_at);
            if (i == 0) chk("busy_run", 32'(busy), 1);
            @(negedge clk);
            if (i == ack_at && i != 4 * ns - 1) begin
                chk("ack_valid_clr", 32'(avg_valid), 0);
                chk("ack_overrun_clr", 32'(overrun), 0);
            end
            if (i == 2) chk("idx_before_strobe", 32'(sample_idx), 0);
            if (i == 3) chk("idx_first_strobe", 32'(sample_idx), 1);
        end
        avg_ack = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_avg"}, 32'(avg), 0);
        chk({tag, "_valid"}, 32'(avg_valid), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_alarm"}, 32'(alarm), 0);
        chk({tag, "_idx"}, 32'(sample_idx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Completion monitor: pre-edge state captured at posedge, judged at the next negedge
    logic       m_en;
    logic       m_rst;
    logic       m_busy;
    logic [1:0] m_idx;

    always @(posedge clk) begin
        m_en   <= en;
        m_rst  <= rst;
        m_busy <= busy;
        m_idx  <= sample_idx;
    end

    always @(negedge clk) begin
        if (m_busy === 1'b1 && m_en === 1'b1 && m_rst === 1'b0 && m_idx == 2'd3
            && sample_idx == 2'd0) begin
            chk("sb_nonempty", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                m_e = sbq.pop_front();
                chk("win_avg0", 32'(avg[8:0]), 32'(m_e.a0));
                chk("win_avg1", 32'(avg[17:9]), 32'(m_e.a1));
                chk("win_alarm", 32'(alarm), 32'(m_e.al));
                chk("win_valid", 32'(avg_valid), 1);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; oneshot = 1'b0; temp = '0; thresh = '0; avg_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // +20 / -20, threshold 0
        thresh = 9'd0;
        w0 = '{9'h014, 9'h014, 9'h014, 9'h014};
        w1 = '{9'h114, 9'h114, 9'h114, 9'h114};
        start_run();
        drive_window(4, -1);
        chk("w1_avg", 32'(avg), 32'({9'h1EC, 9'h014}));
        chk("w1_overrun", 32'(overrun), 0);

        // +1,0,0,0 rounds to 0; negative zero is 0; no ack -> overrun
        w0 = '{9'h001, 9'h000, 9'h000, 9'h000};
        w1 = '{9'h100, 9'h100, 9'h100, 9'h100};
        drive_window(4, -1);
        chk("w2_overrun", 32'(overrun), 1);
        chk("w2_valid", 32'(avg_valid), 1);

        // -1,0,0,0 floors to -1; ack pulse mid-window clears valid/overrun
        thresh = 9'd31;
        w0 = '{9'h101, 9'h000, 9'h000, 9'h000};
        w1 = '{9'd100, 9'd50, 9'h11E, 9'd7};
        drive_window(4, 1);
        chk("w3_overrun", 32'(overrun), 0);

        // extremes; ack coincident with completion keeps valid, no overrun
        thresh = 9'h100;
        w0 = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};
        w1 = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
        drive_window(4, 15);
        chk("w4_valid", 32'(avg_valid), 1);
        chk("w4_overrun", 32'(overrun), 0);

        // drop en after two strobes: partial window discarded, result kept
        w0 = '{9'd90, 9'd90, 9'd90, 9'd90};
        w1 = '{9'd90, 9'd90, 9'd90, 9'd90};
        drive_window(2, -1);
        en = 1'b0;
        @(negedge clk);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_idx", 32'(sample_idx), 0);
        chk("drop_avg", 32'(avg), 32'({9'h101, 9'h0FF}));
        chk("drop_valid", 32'(avg_valid), 1);

        // re-enable in oneshot mode: fresh window, then HOLD
        oneshot = 1'b1;
        thresh = 9'd11;
        w0 = '{9'd10, 9'd11, 9'd12, 9'd13};
        w1 = '{9'h10A, 9'h10B, 9'h10C, 9'h10D};
        start_run();
        drive_window(4, -1);
        chk("hold_busy", 32'(busy), 0);
        chk("hold_overrun", 32'(overrun), 1);
        temp = {9'd77, 9'd77};
        repeat (12) @(negedge clk);
        chk("hold_idx", 32'(sample_idx), 0);
        chk("hold_busy2", 32'(busy), 0);
        chk("hold_avg", 32'(avg), 32'({9'h1F4, 9'h00B}));
        en = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // new run after HOLD -> IDLE, continuous again
        oneshot = 1'b0;
        thresh = 9'd1;
        w0 = '{9'h105, 9'h106, 9'd7, 9'd8};
        w1 = '{9'h100, 9'h100, 9'd3, 9'd0};
        start_run();
        drive_window(4, -1);

        // a few random windows and thresholds
        for (int r = 0; r < 3; r++) begin
            thresh = 9'($urandom);
            for (int k = 0; k < 4; k++) begin
                w0[k] = 9'($urandom);
                w1[k] = 9'($urandom);
            end
            drive_window(4, -1);
        end

        // reset mid-window with a valid result present
        drive_window(1, -1);
        chk("pre_rst_valid", 32'(avg_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
